// File: rtl/shift_issue_stage.sv
// Decode/issue stage for the barrel shifter: decodes R-type shifts into the shifter
// operand bundle and queues them in a 2-entry skid FIFO with valid/ready on both sides.
module shift_issue_stage #(
  parameter int DEPTH = 2,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  instr,
  input  logic [W-1:0] rs_val,
  input  logic [W-1:0] rt_val,
  input  logic         flush,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [1:0]   out_funct,
  output logic [W-1:0] out_a,
  output logic [4:0]   out_N,
  output logic [4:0]   out_rd,
  output logic         illegal
);

  typedef struct packed {
    logic [1:0]   funct;
    logic [W-1:0] a;
    logic [4:0]   n;
    logic [4:0]   rd;
  } entry_t;

  localparam logic [1:0] FULL = 2'(DEPTH);

  function automatic logic is_shift_fn(input logic [5:0] fn);
    case (fn)
      6'b000000, 6'b000010, 6'b000011,
      6'b000100, 6'b000110, 6'b000111: return 1'b1;
      default:                         return 1'b0;
    endcase
  endfunction

  logic [1:0] count_q;
  logic       wr_ptr_q;
  logic       rd_ptr_q;
  logic       illegal_q;
  entry_t     mem_p1 [2];

  logic [5:0] op_p0;
  logic [5:0] fn_p0;
  logic [4:0] rd_p0;
  logic [4:0] shamt_p0;
  logic       legal_p0;
  logic       vld_p0;
  logic       ill_p0;
  logic       in_xfer;
  logic       out_xfer;
  entry_t     dec_p0;
  entry_t     head;
  logic       unused_bits;

  // Stage p0: field decode of the offered instruction
  assign op_p0    = instr[31:26];
  assign rd_p0    = instr[15:11];
  assign shamt_p0 = instr[10:6];
  assign fn_p0    = instr[5:0];
  assign legal_p0 = (op_p0 == 6'd0) && is_shift_fn(fn_p0);

  always_comb begin
    dec_p0       = '0;
    dec_p0.funct = fn_p0[1:0];
    dec_p0.a     = rt_val;
    dec_p0.n     = fn_p0[2] ? rs_val[4:0] : shamt_p0;
    dec_p0.rd    = rd_p0;
  end

  assign unused_bits = ^{instr[25:16], rs_val[W-1:5]};

  assign in_ready  = (count_q < FULL);
  assign out_valid = (count_q != 2'd0);
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;

  // Writes to $zero are consumed silently; flush discards the cycle's input entirely
  assign vld_p0 = in_xfer && legal_p0 && (rd_p0 != 5'd0) && !flush;
  assign ill_p0 = in_xfer && !legal_p0 && !flush;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      if (vld_p0)   wr_ptr_q <= ~wr_ptr_q;
      if (out_xfer) rd_ptr_q <= ~rd_ptr_q;
      case ({vld_p0, out_xfer})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) illegal_q <= 1'b0;
    else       illegal_q <= ill_p0;
  end

  // Stage p1: queued operand bundles
  always_ff @(posedge clk) begin
    if (vld_p0) mem_p1[wr_ptr_q] <= dec_p0;
  end

  assign head      = mem_p1[rd_ptr_q];
  assign out_funct = out_valid ? head.funct : 2'd0;
  assign out_a     = out_valid ? head.a     : '0;
  assign out_N     = out_valid ? head.n     : 5'd0;
  assign out_rd    = out_valid ? head.rd    : 5'd0;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_shift_issue_stage.sv
// Bench for shift_issue_stage: directed scenarios plus a randomized run against a
// queue-based reference model of the issue FIFO.
module tb_shift_issue_stage;

  logic        clk = 1'b0;
  logic        reset, in_valid, flush, out_ready;
  logic        in_ready, out_valid, illegal;
  logic [31:0] instr, rs_val, rt_val, out_a;
  logic [1:0]  out_funct;
  logic [4:0]  out_N, out_rd;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [1:0]  f;
    logic [31:0] a;
    logic [4:0]  n;
    logic [4:0]  rd;
  } ent_t;

  ent_t mq[$];
  logic m_ill = 1'b0;

  always #5 clk = ~clk;

  shift_issue_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .rs_val(rs_val), .rt_val(rt_val), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_funct(out_funct),
    .out_a(out_a), .out_N(out_N), .out_rd(out_rd), .illegal(illegal)
  );

  function automatic logic [31:0] mk(input logic [4:0] rs, input logic [4:0] rt,
                                     input logic [4:0] rd, input logic [4:0] sh,
                                     input logic [5:0] fn);
    return {6'd0, rs, rt, rd, sh, fn};
  endfunction

  function automatic bit legal(input logic [31:0] ins);
    return (ins[31:26] == 6'd0) &&
           (ins[5:0] inside {6'd0, 6'd2, 6'd3, 6'd4, 6'd6, 6'd7});
  endfunction

  function automatic ent_t exp_of(input logic [31:0] ins, input logic [31:0] rs,
                                  input logic [31:0] rt);
    ent_t e;
    e.f  = ins[1:0];
    e.a  = rt;
    e.n  = ins[2] ? rs[4:0] : ins[10:6];
    e.rd = ins[15:11];
    return e;
  endfunction

  task automatic model_step();
    bit rdy, xfer;
    rdy  = (mq.size() < 2);
    xfer = in_valid && rdy;
    if (reset || flush) begin
      mq.delete();
      m_ill = 1'b0;
    end else begin
      if (mq.size() != 0 && out_ready) void'(mq.pop_front());
      if (xfer && legal(instr) && instr[15:11] != 5'd0)
        mq.push_back(exp_of(instr, rs_val, rt_val));
      m_ill = xfer && !legal(instr);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit iv, input logic [31:0] ins, input logic [31:0] rs,
                       input logic [31:0] rt, input bit fl, input bit ordy);
    in_valid  = iv;
    instr     = ins;
    rs_val    = rs;
    rt_val    = rt;
    flush     = fl;
    out_ready = ordy;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1, mk(5'd0, 5'd1, 5'd3, 5'd1, 6'd0), 32'h2, 32'h1234, 0, 0);
    tick();
    tick();
    n_vec++;
    if ({in_ready, out_valid, illegal, out_funct, out_a, out_N, out_rd} !== {1'b1, 1'b0, 1'b0, 44'd0}) begin
      n_err++;
      $display("FAIL reset_state: got %h want %h", {in_ready, out_valid, illegal, out_funct, out_a, out_N, out_rd}, {1'b1, 1'b0, 1'b0, 44'd0});
    end
    reset = 1'b0;
    drive(0, 32'h0, 32'h0, 32'h0, 0, 0);
    tick();
    n_vec++;
    if ({in_ready, out_valid, illegal} !== 3'b100) begin
      n_err++;
      $display("FAIL reset_release: got %b want 100", {in_ready, out_valid, illegal});
    end
  endtask

  task automatic test_basic_sll();
    drive(1, 32'h00041100, 32'h0, 32'h0000000F, 0, 1);
    tick();
    n_vec++;
    if ({out_valid, out_funct, out_a, out_N, out_rd} !== {1'b1, 2'b00, 32'h0000000F, 5'd4, 5'd2}) begin
      n_err++;
      $display("FAIL basic_sll: got %h want %h", {out_valid, out_funct, out_a, out_N, out_rd}, {1'b1, 2'b00, 32'h0000000F, 5'd4, 5'd2});
    end
    drive(0, 32'h0, 32'h0, 32'h0, 0, 1);
    tick();
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL basic_sll_drain: out_valid got %b want 0", out_valid);
    end
  endtask

  task automatic test_srav();
    drive(1, 32'h00A41007, 32'hFFFFFFE3, 32'h80000000, 0, 0);
    tick();
    n_vec++;
    if ({out_valid, out_funct, out_a, out_N, out_rd} !== {1'b1, 2'b11, 32'h80000000, 5'd3, 5'd2}) begin
      n_err++;
      $display("FAIL srav: got %h want %h", {out_valid, out_funct, out_a, out_N, out_rd}, {1'b1, 2'b11, 32'h80000000, 5'd3, 5'd2});
    end
    drive(0, 32'h0, 32'h0, 32'h0, 0, 1);
    tick();
  endtask

  task automatic test_backpressure();
    logic [31:0] ia, ib, ic;
    ent_t ea, eb, ec;
    ia = mk(5'd0, 5'd1, 5'd5, 5'd7, 6'd2);
    ib = mk(5'd3, 5'd2, 5'd6, 5'd0, 6'd4);
    ic = mk(5'd0, 5'd4, 5'd7, 5'd31, 6'd3);
    ea = exp_of(ia, 32'h11, 32'hAAAA0001);
    eb = exp_of(ib, 32'h22, 32'hBBBB0002);
    ec = exp_of(ic, 32'h33, 32'hCCCC0003);
    drive(1, ia, 32'h11, 32'hAAAA0001, 0, 0); tick();
    n_vec++;
    if ({in_ready, out_valid, out_funct, out_a, out_N, out_rd} !== {1'b1, 1'b1, ea}) begin
      n_err++;
      $display("FAIL bp_first: got %h want %h", {in_ready, out_valid, out_funct, out_a, out_N, out_rd}, {1'b1, 1'b1, ea});
    end
    drive(1, ib, 32'h22, 32'hBBBB0002, 0, 0); tick();
    n_vec++;
    if ({in_ready, out_valid, out_funct, out_a, out_N, out_rd} !== {1'b0, 1'b1, ea}) begin
      n_err++;
      $display("FAIL bp_full: got %h want %h", {in_ready, out_valid, out_funct, out_a, out_N, out_rd}, {1'b0, 1'b1, ea});
    end
    drive(1, ic, 32'h33, 32'hCCCC0003, 0, 0); tick();
    n_vec++;
    if ({in_ready, out_valid, out_funct, out_a, out_N, out_rd} !== {1'b0, 1'b1, ea}) begin
      n_err++;
      $display("FAIL bp_hold: got %h want %h", {in_ready, out_valid, out_funct, out_a, out_N, out_rd}, {1'b0, 1'b1, ea});
    end
    drive(1, ic, 32'h33, 32'hCCCC0003, 0, 1); tick();
    n_vec++;
    if ({in_ready, out_valid, out_funct, out_a, out_N, out_rd} !== {1'b1, 1'b1, eb}) begin
      n_err++;
      $display("FAIL bp_pop1: got %h want %h", {in_ready, out_valid, out_funct, out_a, out_N, out_rd}, {1'b1, 1'b1, eb});
    end
    drive(1, ic, 32'h33, 32'hCCCC0003, 0, 1); tick();
    n_vec++;
    if ({in_ready, out_valid, out_funct, out_a, out_N, out_rd} !== {1'b1, 1'b1, ec}) begin
      n_err++;
      $display("FAIL bp_third: got %h want %h", {in_ready, out_valid, out_funct, out_a, out_N, out_rd}, {1'b1, 1'b1, ec});
    end
    drive(0, 32'h0, 32'h0, 32'h0, 0, 1); tick();
    n_vec++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_err++;
      $display("FAIL bp_empty: got %b want 10", {in_ready, out_valid});
    end
  endtask

  task automatic test_illegal();
    logic [31:0] ix;
    ent_t ex;
    ix = mk(5'd0, 5'd9, 5'd12, 5'd17, 6'd0);
    ex = exp_of(ix, 32'h0, 32'h5A5A5A5A);
    drive(1, ix, 32'h0, 32'h5A5A5A5A, 0, 0); tick();
    drive(1, 32'h00000005, 32'h0, 32'h0, 0, 0); tick();
    n_vec++;
    if ({illegal, in_ready, out_valid, out_funct, out_a, out_N, out_rd} !== {1'b1, 1'b1, 1'b1, ex}) begin
      n_err++;
      $display("FAIL illegal_pulse: got %h want %h", {illegal, in_ready, out_valid, out_funct, out_a, out_N, out_rd}, {1'b1, 1'b1, 1'b1, ex});
    end
    drive(0, 32'h0, 32'h0, 32'h0, 0, 0); tick();
    n_vec++;
    if ({illegal, in_ready, out_valid} !== 3'b011) begin
      n_err++;
      $display("FAIL illegal_one_cycle: got %b want 011", {illegal, in_ready, out_valid});
    end
    drive(1, 32'h00000000, 32'h0, 32'h0, 0, 0); tick();
    n_vec++;
    if ({illegal, in_ready, out_valid, out_funct, out_a, out_N, out_rd} !== {1'b0, 1'b1, 1'b1, ex}) begin
      n_err++;
      $display("FAIL nop_drop: got %h want %h", {illegal, in_ready, out_valid, out_funct, out_a, out_N, out_rd}, {1'b0, 1'b1, 1'b1, ex});
    end
    drive(1, 32'h04001000, 32'h0, 32'h0, 0, 0); tick();
    n_vec++;
    if ({illegal, in_ready} !== 2'b11) begin
      n_err++;
      $display("FAIL illegal_opcode: got %b want 11", {illegal, in_ready});
    end
    drive(0, 32'h0, 32'h0, 32'h0, 0, 1); tick();
    n_vec++;
    if ({illegal, out_valid} !== 2'b00) begin
      n_err++;
      $display("FAIL illegal_drain: got %b want 00", {illegal, out_valid});
    end
  endtask

  task automatic test_flush();
    drive(1, mk(5'd0, 5'd1, 5'd1, 5'd1, 6'd0), 32'h0, 32'h1, 0, 0); tick();
    drive(1, mk(5'd0, 5'd2, 5'd2, 5'd2, 6'd2), 32'h0, 32'h2, 0, 0); tick();
    drive(1, 32'h00000005, 32'h0, 32'h0, 1, 0); tick();
    n_vec++;
    if ({out_valid, illegal, in_ready} !== 3'b001) begin
      n_err++;
      $display("FAIL flush_full: got %b want 001", {out_valid, illegal, in_ready});
    end
    drive(1, mk(5'd0, 5'd3, 5'd3, 5'd3, 6'd3), 32'h0, 32'h3, 0, 0); tick();
    drive(1, 32'h00000005, 32'h0, 32'h0, 1, 1); tick();
    n_vec++;
    if ({out_valid, illegal, in_ready} !== 3'b001) begin
      n_err++;
      $display("FAIL flush_illegal_in: got %b want 001", {out_valid, illegal, in_ready});
    end
    drive(1, mk(5'd4, 5'd4, 5'd4, 5'd4, 6'd6), 32'h4, 32'h4, 1, 0); tick();
    n_vec++;
    if ({out_valid, illegal, in_ready} !== 3'b001) begin
      n_err++;
      $display("FAIL flush_legal_in: got %b want 001", {out_valid, illegal, in_ready});
    end
    drive(0, 32'h0, 32'h0, 32'h0, 0, 0); tick();
  endtask

  task automatic test_back_to_back();
    logic [5:0]  fns [4];
    logic [31:0] ins;
    logic [31:0] rsv, rtv;
    ent_t e;
    fns = '{6'd0, 6'd6, 6'd3, 6'd4};
    for (int i = 0; i < 4; i++) begin
      ins = mk(5'(i + 8), 5'(i), 5'(i + 1), 5'(3 * i + 1), fns[i]);
      rsv = $urandom;
      rtv = $urandom;
      e   = exp_of(ins, rsv, rtv);
      drive(1, ins, rsv, rtv, 0, 1); tick();
      n_vec++;
      if ({out_valid, in_ready, out_funct, out_a, out_N, out_rd} !== {1'b1, 1'b1, e}) begin
        n_err++;
        $display("FAIL b2b_%0d: got %h want %h", i, {out_valid, in_ready, out_funct, out_a, out_N, out_rd}, {1'b1, 1'b1, e});
      end
    end
    drive(0, 32'h0, 32'h0, 32'h0, 0, 1); tick();
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_drain: out_valid got %b want 0", out_valid);
    end
  endtask

  task automatic test_random();
    logic [5:0]  fns [6];
    logic [31:0] ins;
    fns = '{6'd0, 6'd2, 6'd3, 6'd4, 6'd6, 6'd7};
    for (int c = 0; c < 600; c++) begin
      case ($urandom_range(0, 9))
        0:       ins = $urandom;
        1:       ins = mk(5'($urandom), 5'($urandom), 5'd0, 5'($urandom), fns[$urandom_range(0, 5)]);
        2:       ins = {6'($urandom_range(1, 63)), 26'($urandom)};
        default: ins = mk(5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), fns[$urandom_range(0, 5)]);
      endcase
      reset = ($urandom_range(0, 79) == 0);
      drive($urandom_range(0, 3) != 0, ins, $urandom, $urandom,
            $urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1);
      tick();
      n_vec++;
      if ({in_ready, out_valid, illegal} !== {mq.size() < 2, mq.size() != 0, m_ill}) begin
        n_err++;
        $display("FAIL rand_ctrl cyc %0d: got %b want %b", c, {in_ready, out_valid, illegal}, {mq.size() < 2, mq.size() != 0, m_ill});
      end
      if (mq.size() != 0) begin
        n_vec++;
        if ({out_funct, out_a, out_N, out_rd} !== mq[0]) begin
          n_err++;
          $display("FAIL rand_head cyc %0d: got %h want %h", c, {out_funct, out_a, out_N, out_rd}, mq[0]);
        end
      end
    end
    reset = 1'b0;
    drive(0, 32'h0, 32'h0, 32'h0, 1, 0); tick();
  endtask

  initial begin
    reset = 1'b0;
    drive(0, 32'h0, 32'h0, 32'h0, 0, 0);
    test_reset();
    test_basic_sll();
    test_srav();
    test_backpressure();
    test_illegal();
    test_flush();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/shift_issue_stage.md
Name: shift_issue_stage

Overview:
Decode/issue stage that sits directly upstream of the 32-bit barrel shifter in the MIPS datapath. It accepts R-type shift instructions with their register operands and decodes them into the shifter's operand bundle: a 2-bit shifter function, the operand `a`, the 5-bit amount `N` and the destination register. It queues these in a 2-entry FIFO (skid buffer) with valid/ready handshakes on both sides, so EX-stage backpressure never drops an instruction. It also supports pipeline flush and flags illegal encodings.

Parameters:
DEPTH, 2, FIFO entries; fixed at 2 (the skid buffer); other values unsupported.
W, 32, datapath width of rs/rt operands and out_a.

Ports:
clk  input  1  rising-edge clock, the only clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  upstream offers instr/rs_val/rt_val
in_ready  output  1  stage can accept this cycle
instr  input  32  MIPS instruction word
rs_val  input  32  value of register rs (variable shift amount source)
rt_val  input  32  value of register rt (data to shift)
flush  input  1  discard all queued entries and this cycle's input
out_valid  output  1  head entry valid
out_ready  input  1  shifter/EX stage consumes head
out_funct  output  2  shifter function: 00 = SLL, 10 = SRL, 11 = SRA
out_a  output  32  operand to shift (= rt_val)
out_N  output  5  shift amount
out_rd  output  5  destination register
illegal  output  1  one-cycle pulse: the previous cycle accepted an illegal encoding

Behaviour:
- Reset (synchronous, sampled on the clk edge): count = 0, out_valid = 0, illegal = 0, in_ready = 1. out_funct, out_a, out_N and out_rd read 0.
- Decode fields: op = instr[31:26], rd = instr[15:11], shamt = instr[10:6], fn = instr[5:0].
- Legal iff op == 0 and fn is one of:
  - 000000 SLL
  - 000010 SRL
  - 000011 SRA
  - 000100 SLLV
  - 000110 SRLV
  - 000111 SRAV
- Decoded fields for a legal instruction:
  - out_funct = fn[1:0].
  - N = fn[2] ? rs_val[4:0] : shamt; the upper 27 bits of rs_val are ignored.
  - a = rt_val.
- Handshake:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - in_ready = (count < 2); it is a registered function of count and does not depend on out_ready.
- Push: an input transfer with a legal instruction and rd != 0 enqueues at the tail.
- Silent drop: a legal instruction with rd == 0 (write to $zero, including NOP 0x00000000) is consumed but not enqueued and does not raise illegal.
- Illegal drop: an illegal instruction is consumed, not enqueued, and illegal = 1 on the next cycle only.
- Pop: an output transfer removes the head. Outputs always present the head entry; out_valid = (count != 0).
- Simultaneous push and pop at count == 1: count stays 1 and the new entry becomes head on the next cycle. At count == 2, push is impossible (in_ready = 0); a pop frees one slot, and in_ready rises on the next cycle.
- Latency: an entry pushed at edge k is visible on out_* with out_valid = 1 after edge k (zero bubbles when empty). Entries leave in strict FIFO order.
- Head stability: out_* hold stable while out_valid && !out_ready.
- Flush (priority over everything): at the edge, count becomes 0 and out_valid = 0 next cycle. Any input transfer in the flush cycle is discarded, including suppressing its illegal pulse. A pop in the flush cycle has no additional effect.
- Reset mid-operation: behaves as flush plus clearing illegal. No partial entries survive.
- count never exceeds 2 or underflows. Pointers are 1 bit and wrap 1 -> 0.

Test Plan:
1. Basic SLL: after reset, push instr 0x00041100 (sll $2,$4,4) with rt_val = 0x0000000F, out_ready = 1 -> next cycle out_valid = 1, out_funct = 00, out_a = 0x0000000F, out_N = 4, out_rd = 2. Then out_valid = 0.
2. Variable SRAV: push 0x00A41007 (srav $2,$4,$5) with rs_val = 0xFFFFFFE3 and rt_val = 0x80000000 -> out_funct = 11, out_N = 3 (rs_val[4:0]), out_a = 0x80000000.
3. Backpressure/full: hold out_ready = 0 and push 3 legal instructions back-to-back -> the first two are accepted, in_ready = 0 on the third. Raise out_ready -> entries drain in order, in_ready returns to 1 the cycle after the first pop, and the third is accepted with no loss or duplication.
4. Illegal and no-op handling: push 0x00000005 (fn = 000101) -> illegal pulses for exactly one cycle and count is unchanged. Push 0x00000000 -> no pulse and nothing enqueued.
5. Flush: with 2 entries queued, assert flush together with an input transfer of an illegal instruction -> next cycle out_valid = 0, count = 0, no illegal pulse, in_ready = 1.
6. Concurrent push/pop at count = 1 with out_ready = 1 for 4 cycles of continuous pushes -> exactly one output per cycle, in order, and out_valid stays 1 throughout.
